// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl
// Adds two packed-BCD operands one digit per cycle, least-significant digit
// first, through a single time-shared one-digit BCD add cell. The operands
// are captured on an accepted start. The inter-digit carry is kept in a
// register. The finished sum, carry-out and invalid-digit flag are announced
// with a one-cycle done pulse.
//
// Handshake: start is sampled only while idle (busy low). A start seen while
// busy is dropped, not queued. done is high for exactly one cycle when sum,
// cout and err become valid. Those outputs then hold until the next accepted
// start.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4,
    parameter int IDXW   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [4*DIGITS-1:0]   r_a;
    logic [4*DIGITS-1:0]   r_b;
    logic [4*DIGITS-1:0]   r_sum;
    logic [IDXW-1:0]       r_idx;
    logic                  r_carry;
    logic                  r_cout;
    logic                  r_err;

    logic [3:0]            w_dig_a;
    logic [3:0]            w_dig_b;
    logic [4:0]            w_s;
    logic                  w_gt9;
    logic [3:0]            w_digit;
    logic                  w_last;
    logic                  w_bad;

    // Digit currently being processed, selected by the digit index.
    assign w_dig_a = r_a[4*int'(r_idx) +: 4];
    assign w_dig_b = r_b[4*int'(r_idx) +: 4];

    // One-digit BCD add cell. Adding 6 modulo 16 corrects any total above 9.
    assign w_s     = {1'b0, w_dig_a} + {1'b0, w_dig_b} + {4'b0000, r_carry};
    assign w_gt9   = (w_s > 5'd9);
    assign w_digit = w_gt9 ? (w_s[3:0] + 4'd6) : w_s[3:0];
    assign w_last  = (r_idx == IDXW'(DIGITS - 1));

    // Flags any operand digit outside 0..9 at capture time.
    always_comb begin
        w_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if ((a[4*d +: 4] > 4'd9) || (b[4*d +: 4] > 4'd9)) begin
                w_bad = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> ADD on start, ADD -> DONE after the top digit,
    // DONE -> IDLE after one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ADD;
            S_ADD:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture the operands, step the digits, and hold the results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_sum   <= '0;
                        r_idx   <= '0;
                        r_err   <= w_bad;
                    end
                end
                S_ADD: begin
                    r_sum[4*int'(r_idx) +: 4] <= w_digit;
                    r_carry                   <= w_gt9;
                    if (w_last) begin
                        r_cout <= w_gt9;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Testbench for bcd_serial_add_ctrl.
// A model builds the whole per-cycle output trace of an operation when it
// accepts the operation. Every falling edge compares the DUT outputs with
// that trace. Directed cases pin the known sums, the latency and the async
// reset. Random operations cover the rest.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int IDXW   = 3;
  localparam int W      = 4 * DIGITS;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  typedef struct packed {
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } snap_t;

  snap_t exp_q[$];
  snap_t cur = '0;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // model: on acceptance, precompute the visible outputs for every cycle of the operation
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    snap_t s;
    logic [W-1:0] part;
    logic         bad;
    int           c;
    int           t;
    bad = 1'b0;
    for (int d = 0; d < DIGITS; d++)
      if (av[4*d +: 4] > 9 || bv[4*d +: 4] > 9) bad = 1'b1;
    s = cur;
    s.busy = 1'b1;
    s.done = 1'b0;
    s.err  = bad;
    s.sum  = '0;
    cur = s;
    part = '0;
    c = int'(cv);
    for (int d = 0; d < DIGITS; d++) begin
      t = int'(av[4*d +: 4]) + int'(bv[4*d +: 4]) + c;
      if (t > 9) begin
        part[4*d +: 4] = 4'((t + 6) % 16);
        c = 1;
      end else begin
        part[4*d +: 4] = 4'(t);
        c = 0;
      end
      s.sum = part;
      if (d == DIGITS - 1) begin
        s.done = 1'b1;
        s.cout = c[0];
      end
      exp_q.push_back(s);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur = '0;
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else if (cur.busy) begin
      cur.busy = 1'b0;
      cur.done = 1'b0;
    end else if (start) begin
      accept(a, b, cin);
    end
  end

  // scoreboard compare, once per cycle, away from the active edge
  always @(negedge clk) begin
    cyc++;
    check("busy", 32'(busy), 32'(cur.busy));
    check("done", 32'(done), 32'(cur.done));
    check("sum",  32'(sum),  32'(cur.sum));
    check("cout", 32'(cout), 32'(cur.cout));
    check("err",  32'(err),  32'(cur.err));
  end

  // driver tasks
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input logic [W-1:0] e_sum, input logic e_cout, input logic e_err,
                        input bit poke);
    int lat;
    int nbusy;
    wait_idle();
    @(posedge clk);
    #2;
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    lat = 0;
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) nbusy++;
      if (poke && lat == 2) begin
        a = ~av; b = ~bv; cin = ~cv; start = 1'b1;
      end
      if (poke && lat == 3) start = 1'b0;
      if (done === 1'b1) break;
    end
    check("latency",   32'(lat),   32'(DIGITS + 1));
    check("busy_len",  32'(nbusy), 32'(DIGITS + 1));
    check("lit_sum",   32'(sum),   32'(e_sum));
    check("lit_cout",  32'(cout),  32'(e_cout));
    check("lit_err",   32'(err),   32'(e_err));
    check("model_sum", 32'(cur.sum), 32'(e_sum));
  endtask

  initial begin
    int t_done[$];
    // reset held for a few cycles, and outputs checked there by the compare process
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // directed sums
    run_op(16'h0450, 16'h0321, 1'b0, 16'h0771, 1'b0, 1'b0, 0);
    run_op(16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h0009, 16'h0009, 1'b1, 16'h0019, 1'b0, 1'b0, 0);
    run_op(16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1, 0);
    run_op(16'h0450, 16'h0321, 1'b0, 16'h0771, 1'b0, 1'b0, 0);
    // start pulse while busy is ignored
    run_op(16'h2718, 16'h3141, 1'b1, 16'h5860, 1'b0, 1'b0, 1);

    // start held high: back-to-back operations
    wait_idle();
    @(posedge clk);
    #2;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 30 && t_done.size() < 2; i++) begin
      @(negedge clk);
      if (done === 1'b1) t_done.push_back(cyc);
    end
    start = 1'b0;
    if (t_done.size() == 2) check("b2b_gap", 32'(t_done[1] - t_done[0]), 32'd6);
    else check("b2b_count", 32'(t_done.size()), 32'd2);

    // asynchronous reset in the middle of an operation
    wait_idle();
    @(posedge clk);
    #2;
    a = 16'h12A3; b = 16'h0456; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

    // random operations
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      bit wild;
      wild = ($urandom_range(0, 3) == 0);
      for (int d = 0; d < DIGITS; d++) begin
        ra[4*d +: 4] = 4'(wild ? $urandom_range(0, 15) : $urandom_range(0, 9));
        rb[4*d +: 4] = 4'(wild ? $urandom_range(0, 15) : $urandom_range(0, 9));
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(posedge clk);
      #2;
      a = ra; b = rb; cin = 1'($urandom_range(0, 1)); start = 1'b1;
      @(posedge clk);
      #2;
      start = ($urandom_range(0, 3) == 0);
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #2 start = 1'b0;
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
